// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the program-counter unit:
//   - pcState_e : fetch-front FSM state (boot, run, flush bubble)
//   - XLEN_DEF / STEP_DEF : default PC width and sequential step
//   - align_mask : mask that clears the low alignment bits of an address
// -----------------------------------------------------------------------------
package pc_pkg;

    typedef enum logic [1:0] {
        PC_BOOT  = 2'd0,
        PC_RUN   = 2'd1,
        PC_FLUSH = 2'd2
    } pcState_e;

    localparam int unsigned XLEN_DEF = 8;
    localparam int unsigned STEP_DEF = 4;

    // Produced 64 bits wide so callers of any XLEN up to 64 can truncate it.
    function automatic logic [63:0] align_mask(input int unsigned alignBits);
        return ~((64'd1 << alignBits) - 64'd1);
    endfunction

endpackage

// File: rtl/pc_unit_adder.sv
// -----------------------------------------------------------------------------
// pc_adder
// Sequential PC incrementer: sum = pc + STEP modulo 2^XLEN, with the carry
// out exposed so the caller can flag an address-space wrap.
// Ports:
//   i_pc    in  XLEN  current PC
//   o_sum   out XLEN  pc + STEP, truncated
//   o_carry out 1     carry out of the addition
// -----------------------------------------------------------------------------
module pc_adder #(
    parameter int unsigned XLEN = 8,
    parameter int unsigned STEP = 4
) (
    input  logic [XLEN-1:0] i_pc,
    output logic [XLEN-1:0] o_sum,
    output logic            o_carry
);

    localparam logic [XLEN:0] STEP_EXT = (XLEN+1)'(STEP);

    // One extra bit of width captures the carry out of the top PC bit.
    assign {o_carry, o_sum} = {1'b0, i_pc} + STEP_EXT;

endmodule

// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit
// Program counter at the front of the fetch stage: sequential increment,
// branch/jump redirect, trap redirect, exception-PC capture, boot sequencing,
// stall and post-redirect bubble cycles.
// Ports:
//   clk             in  1     rising-edge clock
//   rst_n           in  1     asynchronous active-low reset
//   stall           in  1     hold PC this cycle (RUN only)
//   redirect_valid  in  1     branch/jump taken
//   redirect_target in  XLEN  branch/jump target
//   trap_valid      in  1     trap request
//   trap_vec        in  XLEN  trap handler base
//   pc              out XLEN  current fetch PC
//   pc_next_seq     out XLEN  pc + STEP (wraps)
//   pc_valid        out 1     pc is a valid fetch address this cycle
//   epc             out XLEN  PC captured at the last trap
//   misalign_fault  out 1     pulse: misaligned redirect target seen
//   wrap            out 1     pulse: sequential increment wrapped
// -----------------------------------------------------------------------------
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = XLEN_DEF,
    parameter int unsigned     STEP         = STEP_DEF,
    parameter logic [XLEN-1:0] RESET_VEC    = '0,
    parameter int unsigned     ALIGN_BITS   = 2,
    parameter int unsigned     FLUSH_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vec,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next_seq,
    output logic            pc_valid,
    output logic [XLEN-1:0] epc,
    output logic            misalign_fault,
    output logic            wrap
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(align_mask(ALIGN_BITS));
    // A misaligned reset vector is silently rounded down to a legal address.
    localparam logic [XLEN-1:0] RESET_PC   = RESET_VEC & ALIGN_MASK;
    localparam logic [2:0]      FLUSH_LOAD = 3'(FLUSH_CYCLES);
    localparam bit              HAS_FLUSH  = (FLUSH_CYCLES != 0);

    pcState_e        r_state;
    pcState_e        w_stateNext;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pcNext;
    logic [XLEN-1:0] r_epc;
    logic [XLEN-1:0] w_epcNext;
    logic [2:0]      r_flushCnt;
    logic [2:0]      w_flushCntNext;
    logic            r_misalign;
    logic            w_misalignNext;
    logic            r_wrap;
    logic            w_wrapNext;

    logic [XLEN-1:0] w_pcSum;
    logic            w_pcCarry;
    logic            w_targetMisaligned;
    logic [XLEN-1:0] w_trapTarget;

    pc_adder #(
        .XLEN (XLEN),
        .STEP (STEP)
    ) u_adder (
        .i_pc    (r_pc),
        .o_sum   (w_pcSum),
        .o_carry (w_pcCarry)
    );

    assign w_targetMisaligned = |(redirect_target & ~ALIGN_MASK);
    assign w_trapTarget       = trap_vec & ALIGN_MASK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= PC_BOOT;
            r_pc       <= RESET_PC;
            r_epc      <= '0;
            r_flushCnt <= '0;
            r_misalign <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_pc       <= w_pcNext;
            r_epc      <= w_epcNext;
            r_flushCnt <= w_flushCntNext;
            r_misalign <= w_misalignNext;
            r_wrap     <= w_wrapNext;
        end
    end

    // Next-state logic. A misaligned redirect is turned into a trap so the
    // fetch stage never sees an illegal address. Redirects and traps are
    // honoured identically in RUN and FLUSH; only BOOT ignores them.
    always_comb begin
        w_stateNext    = r_state;
        w_pcNext       = r_pc;
        w_epcNext      = r_epc;
        w_flushCntNext = r_flushCnt;
        w_misalignNext = 1'b0;
        w_wrapNext     = 1'b0;

        case (r_state)
            PC_BOOT: begin
                w_stateNext = PC_RUN;
            end

            PC_RUN, PC_FLUSH: begin
                if (trap_valid || (redirect_valid && w_targetMisaligned)) begin
                    w_pcNext       = w_trapTarget;
                    w_epcNext      = r_pc;
                    w_misalignNext = !trap_valid;
                end else if (redirect_valid) begin
                    w_pcNext = redirect_target;
                end

                if (trap_valid || redirect_valid) begin
                    w_flushCntNext = FLUSH_LOAD;
                    w_stateNext    = HAS_FLUSH ? PC_FLUSH : PC_RUN;
                end else if (r_state == PC_FLUSH) begin
                    // Counter holds the bubbles still owed including this one.
                    w_flushCntNext = r_flushCnt - 3'd1;
                    if (r_flushCnt <= 3'd1) begin
                        w_stateNext = PC_RUN;
                    end
                end else if (!stall) begin
                    w_pcNext   = w_pcSum;
                    w_wrapNext = w_pcCarry;
                end
            end

            default: begin
                w_stateNext = PC_BOOT;
            end
        endcase
    end

    assign pc             = r_pc;
    assign pc_next_seq    = w_pcSum;
    assign pc_valid       = (r_state == PC_RUN);
    assign epc            = r_epc;
    assign misalign_fault = r_misalign;
    assign wrap           = r_wrap;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit: PC register, sequential increment, branch/jump redirect, trap redirect and exception-PC capture in one block.
- Sits at the front of the fetch stage. It feeds instruction memory and the PMP check, and takes redirects from execute and traps from the PMP/trap logic.
- Generalises the fixed 8-bit PC+4 incrementer to any width and step, and adds boot sequencing, stall, redirect bubbles and misaligned-target detection.

Parameters:
- XLEN, 8, PC width in bits.
- STEP, 4, sequential increment in bytes.
- RESET_VEC, 0, PC value loaded on reset.
- ALIGN_BITS, 2, low PC bits that must be zero for a legal target.
- FLUSH_CYCLES, 1, bubble cycles (pc_valid low) after any redirect or trap; legal range 0..7.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC this cycle.
- redirect_valid  in  1  branch/jump taken.
- redirect_target  in  XLEN  branch/jump target.
- trap_valid  in  1  trap request (e.g. PMP fault).
- trap_vec  in  XLEN  trap handler base.
- pc  out  XLEN  current fetch PC.
- pc_next_seq  out  XLEN  pc+STEP (combinational, wraps).
- pc_valid  out  1  pc is a valid fetch address this cycle.
- epc  out  XLEN  PC captured at the last trap.
- misalign_fault  out  1  one-cycle pulse: misaligned redirect target seen.
- wrap  out  1  one-cycle pulse: a sequential increment wrapped past 2^XLEN.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - pc=RESET_VEC, epc=0.
  - pc_valid=0, misalign_fault=0, wrap=0.
  - state=BOOT, flush counter=0.
- FSM states:
  - BOOT: one cycle with pc_valid=0 after reset release, then RUN.
  - RUN: pc_valid=1.
  - FLUSH: pc_valid=0 for FLUSH_CYCLES cycles, then RUN.
  - With FLUSH_CYCLES=0 the block never enters FLUSH; a redirect takes effect and pc_valid stays 1.
- Per-cycle priority in RUN, highest first:
  1. trap_valid: pc<=trap_vec with low ALIGN_BITS forced to 0; epc<=pc; enter FLUSH.
  2. redirect_valid with target low ALIGN_BITS != 0: treated as a trap. pc<=aligned trap_vec; epc<=pc; misalign_fault=1 next cycle; enter FLUSH.
  3. redirect_valid, aligned target: pc<=redirect_target; enter FLUSH.
  4. stall: pc holds.
  5. Otherwise: pc<=pc+STEP mod 2^XLEN. If the carry out is set, wrap=1 next cycle.
- Stall and redirect/trap in the same cycle: the redirect/trap wins; stall is ignored.
- trap_valid and redirect_valid together: the trap wins, misalign_fault stays 0, and redirect_target is ignored.
- In FLUSH:
  - stall is ignored and the counter decrements every cycle.
  - A new trap or redirect updates pc/epc as in RUN and reloads the counter to FLUSH_CYCLES.
  - With no new event, pc holds.
- In BOOT: trap_valid and redirect_valid are ignored; pc holds RESET_VEC.
- pc_next_seq = pc+STEP truncated to XLEN in all states, including reset.
- Latency: a redirect or trap presented in cycle N changes pc at the clock edge ending cycle N; the new pc is visible in N+1.
- Reset asserted mid-FLUSH or mid-stall: immediate return to reset values; no epc retention.
- misalign_fault and wrap are registered single-cycle pulses that clear the following cycle unless re-triggered.
- RESET_VEC must itself be aligned. If it is not, its low ALIGN_BITS are forced to 0 at elaboration.

Decomposition:
- Shared package pc_pkg holds:
  - state enum PC_BOOT/PC_RUN/PC_FLUSH (2 bits);
  - default localparams XLEN_DEF=8 and STEP_DEF=4;
  - an align-mask helper function.
- One natural sub-module: the existing PC incrementer, generalised to pc_adder (parameters XLEN, STEP; outputs sum and carry). pc_unit instantiates it for pc_next_seq and wrap detection.

Test Plan:
- Reset release, no stimulus, XLEN=8:
  - pc=0x00 with pc_valid=0 for one cycle;
  - then pc=0x00,0x04,0x08,… with pc_valid=1.
- Free-run from 0xF8: pc goes 0xF8 → 0xFC → 0x00, with wrap=1 in the cycle pc=0x00 and wrap=0 the next cycle.
- At pc=0x10: stall for 3 cycles → pc holds 0x10; then resumes 0x14.
- redirect_valid with target 0x40 and FLUSH_CYCLES=1:
  - next cycle pc=0x40 with pc_valid=0;
  - following cycle pc_valid=1; then pc=0x44.
- redirect target 0x42 at pc=0x20 with trap_vec=0x80:
  - pc=0x80, epc=0x20, misalign_fault pulses once.
- trap_valid, redirect_valid and stall all high at pc=0x30, trap_vec=0x83:
  - pc=0x80, epc=0x30, misalign_fault=0.
  - Then pull rst_n low mid-FLUSH → all outputs return to reset values asynchronously.
